data_sram_slave: RTL and testbench
==================================

# data_sram_slave

Responder for the CPU data-SRAM port (en / wen / addr / wdata → rdata). It contains a word-organised on-chip RAM with byte-enable writes and a small memory-mapped I/O window. The I/O window holds an LED register, synchronised switch inputs, and a free-running timer with compare interrupt. It sits between the CPU core's data port and the board, in place of the bare data RAM in the SoC top.

## Interface
Parameters:
- `ADDR_W`, default 10: RAM word-address bits (RAM depth = 2^ADDR_W words).

Ports:
- `clk` in 1: sole clock; all state on rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `data_sram_en` in 1: access strobe for this cycle.
- `data_sram_wen` in 4: byte write enables; 0000 means read; bit i covers wdata[8i+7:8i].
- `data_sram_addr` in 32: byte address; bits [1:0] ignored.
- `data_sram_wdata` in 32: write data.
- `data_sram_rdata` out 32: registered read data.
- `led` out 16: LED register.
- `switch` in 8: asynchronous board switches.
- `timer_int` out 1: timer compare interrupt, level, sticky.

## Operation
Address decode, on `en=1`:
- `addr[31:16]==16'hbfaf` selects I/O; `addr[15:0]` is the offset.
- Any other address selects RAM, word index `addr[ADDR_W+1:2]`. Upper bits are aliased.

RAM:
- Write: each byte lane with `wen[i]=1` is updated; other lanes are kept.
- Read-first: `rdata` after any RAM access (read or write) is the pre-write word at that index.
- RAM contents are not reset.

I/O registers (reads return bits zero-extended to 32):
- `0xf000` LED, R/W, 16 bits. A write takes `wdata[15:0]` under `wen[1:0]` byte lanes; `wen[3:2]` is ignored.
- `0xf004` SWITCH, RO, 8 bits. Value is `switch` after a 2-flop synchroniser; writes are ignored.
- `0xe000` TIMER, R/W, 32 bits. Increments by 1 every cycle and wraps 0xffffffff→0. A write (any nonzero `wen`) loads full `wdata`, ignoring individual lanes. The write wins over the increment in that cycle.
- `0xe004` COMPARE, R/W, 32 bits. Written as a full word. A write also clears `timer_int`.
- All other offsets: reads return 0; writes are ignored.

Interrupt:
- `timer_int` sets on the cycle after `TIMER==COMPARE` while `COMPARE!=0`.
- It stays set until COMPARE is written.
- If set and clear occur in the same cycle, clear wins.

`rdata` update rules:
- Updated only in cycles with `en=1`.
- Holds its previous value while `en=0`.
- Write accesses to I/O also update `rdata`, with the pre-write register value.

## Timing
- Read latency 1: address sampled at edge N, `rdata` valid after edge N and stable until the next `en=1` edge.
- Back-to-back accesses are allowed every cycle. There is no stall or ready signal, so the responder never back-pressures.
- Write side effects are visible to an access issued on the following cycle.
- Switch path: a change on `switch` is visible in SWITCH reads sampled 2 edges later (3rd edge into `rdata`).
- TIMER read returns the value held before the sampling edge.
- Reset values:
  - `rdata`, `led`, TIMER, COMPARE, `timer_int`, synchroniser flops: 0.
  - Reset mid-access aborts that access: no write occurs and `rdata` is 0.
  - TIMER first reads 0 at the first edge after deassertion and then counts.

## Configuration
- `DATA_SRAM_SLAVE_TIMER_EN` defined: TIMER, COMPARE and `timer_int` are implemented as above.
- Not defined:
  - No timer or compare flops are built.
  - Offsets `0xe000` and `0xe004` read 0 and ignore writes.
  - `timer_int` is tied 0.
  - RAM, LED and SWITCH behaviour is unchanged.

## Test plan
- RAM byte lanes: write 0x11223344 (wen=1111) to 0x00000010, write 0xAABBCCDD with wen=0101, read 0x10 → `rdata`=0x11BB33DD one cycle after the read.
- Read-first and hold: write 0x5 to word 3 with the word holding 0x9 → `rdata`=0x9. Then drop `en` for 3 cycles → `rdata` stays 0x9. Then read → 0x5.
- LED/unmapped I/O: write 0xFFFF1234 (wen=1111) to 0xbfaff000 → `led`=0x1234, readback 0x00001234. Write to 0xbfaff100, then read it → 0 and `led` unchanged.
- Switch sync: `switch`=0xA5 applied; a read issued 1 edge later returns the old value; a read issued 2 edges later returns 0x000000A5.
- Timer (macro on): write TIMER=0xFFFFFFFE, COMPARE=0x1 → TIMER wraps through 0, `timer_int` rises one cycle after TIMER==1 and stays high. Write COMPARE=0 → `timer_int`=0 next cycle and does not re-assert.
- Reset: assert `resetn`=0 mid-write to LED → `led`=0, `rdata`=0, `timer_int`=0 immediately (asynchronous). Macro off: TIMER read → 0 and `timer_int` constant 0.

Source files
------------

// File: rtl/data_sram_slave.sv
// Data-SRAM port responder: byte-lane RAM plus an I/O window (LED, synchronised switches, timer).
// Define DATA_SRAM_SLAVE_TIMER_EN to build the TIMER/COMPARE registers and timer_int.
module data_sram_slave #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              data_sram_en,
    input  logic [3:0]        data_sram_wen,
    input  logic [31:0]       data_sram_addr,
    input  logic [31:0]       data_sram_wdata,
    output logic [31:0]       data_sram_rdata,
    output logic [15:0]       led,
    input  logic [7:0]        switch,
    output logic              timer_int
);

    localparam int DEPTH = 1 << ADDR_W;

    logic              ioSel;
    logic [15:0]       ioOffset;
    logic [ADDR_W-1:0] ramIndex;
    logic              ioWrite;
    logic [31:0]       ioRdata;

    logic [31:0]       ram [DEPTH];
    logic [31:0]       ramQ;
    logic              selRam;
    logic [31:0]       ioQ;

    logic [7:0]        swMeta;
    logic [7:0]        swSync;

    assign ioSel    = (data_sram_addr[31:16] == 16'hbfaf);
    assign ioOffset = data_sram_addr[15:0];
    assign ramIndex = data_sram_addr[ADDR_W+1:2];
    assign ioWrite  = data_sram_en && ioSel && (data_sram_wen != 4'b0000);

    // Unreset RAM; the resetn qualifier makes an access caught by reset leave memory untouched.
    always_ff @(posedge clk) begin
        if (data_sram_en && resetn) begin
            ramQ <= ram[ramIndex];
            if (!ioSel) begin
                for (int i = 0; i < 4; i++) begin
                    if (data_sram_wen[i]) begin
                        ram[ramIndex][8*i +: 8] <= data_sram_wdata[8*i +: 8];
                    end
                end
            end
        end
    end

    // Response source is captured per access, so rdata holds while en is low and clears on reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            selRam <= 1'b0;
            ioQ    <= 32'h0;
        end else if (data_sram_en) begin
            selRam <= !ioSel;
            ioQ    <= ioSel ? ioRdata : 32'h0;
        end
    end

    assign data_sram_rdata = selRam ? ramQ : ioQ;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            swMeta <= 8'h0;
            swSync <= 8'h0;
        end else begin
            swMeta <= switch;
            swSync <= swMeta;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            led <= 16'h0;
        end else if (ioWrite && (ioOffset == 16'hf000)) begin
            if (data_sram_wen[0]) led[7:0]  <= data_sram_wdata[7:0];
            if (data_sram_wen[1]) led[15:8] <= data_sram_wdata[15:8];
        end
    end

`ifdef DATA_SRAM_SLAVE_TIMER_EN
    logic [31:0] timer;
    logic [31:0] compare;
    logic        timerWrite;
    logic        compareWrite;

    assign timerWrite   = ioWrite && (ioOffset == 16'he000);
    assign compareWrite = ioWrite && (ioOffset == 16'he004);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            timer <= 32'h0;
        end else if (timerWrite) begin
            timer <= data_sram_wdata;
        end else begin
            timer <= timer + 32'd1;
        end
    end

    // A COMPARE write both re-arms and clears, taking priority over a match in the same cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            compare   <= 32'h0;
            timer_int <= 1'b0;
        end else if (compareWrite) begin
            compare   <= data_sram_wdata;
            timer_int <= 1'b0;
        end else if ((timer == compare) && (compare != 32'h0)) begin
            timer_int <= 1'b1;
        end
    end
`else
    assign timer_int = 1'b0;
`endif

    always_comb begin
        ioRdata = 32'h0;
        case (ioOffset)
            16'hf000: ioRdata = {16'h0, led};
            16'hf004: ioRdata = {24'h0, swSync};
`ifdef DATA_SRAM_SLAVE_TIMER_EN
            16'he000: ioRdata = timer;
            16'he004: ioRdata = compare;
`endif
            default:  ioRdata = 32'h0;
        endcase
    end

endmodule

// File: tb/tb_data_sram_slave.sv
// Scoreboard bench for data_sram_slave: expected read data queued at issue, compared one edge later.
module tb_data_sram_slave;

    logic        clk;
    logic        resetn;
    logic        en;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [15:0] led;
    logic [7:0]  sw;
    logic        timerInt;

    int errors = 0;
    int checks = 0;
    logic [31:0] sb[$];

    data_sram_slave #(.ADDR_W(10)) dut (
        .clk             (clk),
        .resetn          (resetn),
        .data_sram_en    (en),
        .data_sram_wen   (wen),
        .data_sram_addr  (addr),
        .data_sram_wdata (wdata),
        .data_sram_rdata (rdata),
        .led             (led),
        .switch          (sw),
        .timer_int       (timerInt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one access, sampled at the next edge; returns 1 ns after that edge with en dropped.
    task automatic drive(input logic [3:0] w, input logic [31:0] a, input logic [31:0] d,
                         input bit chk, input logic [31:0] exp);
        en = 1'b1; wen = w; addr = a; wdata = d;
        if (chk) sb.push_back(exp);
        @(posedge clk); #1;
        en = 1'b0; wen = 4'b0000;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic test_reset;
        resetn = 1'b0; en = 1'b0; wen = 4'b0; addr = 32'h0; wdata = 32'h0; sw = 8'h00;
        #2;
        checks++; if (rdata !== 32'h0) begin errors++; $display("[TB] FAIL reset_rdata: got 0x%08h, expected 0x00000000", rdata); end
        checks++; if (led !== 16'h0) begin errors++; $display("[TB] FAIL reset_led: got 0x%04h, expected 0x0000", led); end
        checks++; if (timerInt !== 1'b0) begin errors++; $display("[TB] FAIL reset_int: got %b, expected 0", timerInt); end
        repeat (2) @(posedge clk);
        @(negedge clk) resetn = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_ram_lanes;
        logic [3:0]  w [5] = '{4'b1111, 4'b0101, 4'b0000, 4'b0000, 4'b0011};
        logic [31:0] a [5] = '{32'h10, 32'h10, 32'h10, 32'h0000_1010, 32'h14};
        logic [31:0] d [5] = '{32'h11223344, 32'hAABBCCDD, 32'h0, 32'h0, 32'h0000BEEF};
        bit          c [5] = '{0, 1, 1, 1, 0};
        logic [31:0] e [5] = '{32'h0, 32'h11223344, 32'h11BB33DD, 32'h11BB33DD, 32'h0};
        logic [31:0] exp;
        for (int i = 0; i < 5; i++) begin
            drive(w[i], a[i], d[i], c[i], e[i]);
            if (c[i]) begin
                exp = sb.pop_front();
                checks++;
                if (rdata !== exp) begin errors++; $display("[TB] FAIL ram_lanes[%0d]: got 0x%08h, expected 0x%08h", i, rdata, exp); end
            end
        end
    endtask

    task automatic test_read_first_hold;
        logic [31:0] exp;
        drive(4'b1111, 32'hC, 32'h9, 1'b0, 32'h0);
        drive(4'b1111, 32'hC, 32'h5, 1'b1, 32'h9);
        exp = sb.pop_front();
        checks++; if (rdata !== exp) begin errors++; $display("[TB] FAIL read_first: got 0x%08h, expected 0x%08h", rdata, exp); end
        for (int i = 0; i < 3; i++) begin
            idle(1);
            checks++; if (rdata !== 32'h9) begin errors++; $display("[TB] FAIL hold[%0d]: got 0x%08h, expected 0x00000009", i, rdata); end
        end
        drive(4'b0000, 32'hC, 32'h0, 1'b1, 32'h5);
        exp = sb.pop_front();
        checks++; if (rdata !== exp) begin errors++; $display("[TB] FAIL reread: got 0x%08h, expected 0x%08h", rdata, exp); end
    endtask

    task automatic test_led_io;
        logic [3:0]  w [7] = '{4'b1111, 4'b0000, 4'b0010, 4'b1100, 4'b1111, 4'b0000, 4'b0000};
        logic [31:0] a [7] = '{32'hbfaff000, 32'hbfaff000, 32'hbfaff000, 32'hbfaff000,
                               32'hbfaff100, 32'hbfaff100, 32'hbfaff000};
        logic [31:0] d [7] = '{32'hFFFF1234, 32'h0, 32'h0000AB00, 32'hFFFFFFFF, 32'hDEADBEEF, 32'h0, 32'h0};
        logic [31:0] e [7] = '{32'h0, 32'h1234, 32'h1234, 32'hAB34, 32'h0, 32'h0, 32'hAB34};
        logic [15:0] l [7] = '{16'h1234, 16'h1234, 16'hAB34, 16'hAB34, 16'hAB34, 16'hAB34, 16'hAB34};
        logic [31:0] exp;
        for (int i = 0; i < 7; i++) begin
            drive(w[i], a[i], d[i], 1'b1, e[i]);
            exp = sb.pop_front();
            checks++;
            if (rdata !== exp) begin errors++; $display("[TB] FAIL io_rdata[%0d]: got 0x%08h, expected 0x%08h", i, rdata, exp); end
            checks++;
            if (led !== l[i]) begin errors++; $display("[TB] FAIL led[%0d]: got 0x%04h, expected 0x%04h", i, led, l[i]); end
        end
    endtask

    task automatic test_switch_sync;
        logic [31:0] e [3] = '{32'h0, 32'hA5, 32'hA5};
        logic [3:0]  w [3] = '{4'b0000, 4'b0000, 4'b1111};
        logic [31:0] exp;
        sw = 8'hA5;
        idle(1);
        for (int i = 0; i < 3; i++) begin
            drive(w[i], 32'hbfaff004, 32'hFFFFFFFF, 1'b1, e[i]);
            exp = sb.pop_front();
            checks++;
            if (rdata !== exp) begin errors++; $display("[TB] FAIL switch[%0d]: got 0x%08h, expected 0x%08h", i, rdata, exp); end
        end
        drive(4'b0000, 32'hbfaff004, 32'h0, 1'b1, 32'hA5);
        exp = sb.pop_front();
        checks++; if (rdata !== exp) begin errors++; $display("[TB] FAIL switch_ro: got 0x%08h, expected 0x%08h", rdata, exp); end
    endtask

`ifdef DATA_SRAM_SLAVE_TIMER_EN
    task automatic test_timer;
        logic [3:0]  w [5] = '{4'b1111, 4'b1111, 4'b0000, 4'b0000, 4'b0000};
        logic [31:0] a [5] = '{32'hbfafe000, 32'hbfafe004, 32'hbfafe000, 32'hbfafe000, 32'hbfafe000};
        logic [31:0] d [5] = '{32'hFFFFFFFE, 32'h1, 32'h0, 32'h0, 32'h0};
        bit          c [5] = '{0, 1, 1, 1, 1};
        logic [31:0] e [5] = '{32'h0, 32'h0, 32'hFFFFFFFF, 32'h0, 32'h1};
        logic        ie [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic [31:0] exp;
        for (int i = 0; i < 5; i++) begin
            drive(w[i], a[i], d[i], c[i], e[i]);
            if (c[i]) begin
                exp = sb.pop_front();
                checks++;
                if (rdata !== exp) begin errors++; $display("[TB] FAIL timer_rd[%0d]: got 0x%08h, expected 0x%08h", i, rdata, exp); end
            end
            checks++;
            if (timerInt !== ie[i]) begin errors++; $display("[TB] FAIL timer_int[%0d]: got %b, expected %b", i, timerInt, ie[i]); end
        end
        idle(3);
        checks++; if (timerInt !== 1'b1) begin errors++; $display("[TB] FAIL int_sticky: got %b, expected 1", timerInt); end
        drive(4'b1111, 32'hbfafe004, 32'h0, 1'b1, 32'h1);
        exp = sb.pop_front();
        checks++; if (rdata !== exp) begin errors++; $display("[TB] FAIL cmp_prewrite: got 0x%08h, expected 0x%08h", rdata, exp); end
        checks++; if (timerInt !== 1'b0) begin errors++; $display("[TB] FAIL int_clear: got %b, expected 0", timerInt); end
        idle(4);
        checks++; if (timerInt !== 1'b0) begin errors++; $display("[TB] FAIL int_rearm: got %b, expected 0", timerInt); end
    endtask
`else
    task automatic test_timer;
        logic [31:0] exp;
        drive(4'b1111, 32'hbfafe000, 32'h12345678, 1'b1, 32'h0);
        drive(4'b1111, 32'hbfafe004, 32'h00000003, 1'b1, 32'h0);
        drive(4'b0000, 32'hbfafe000, 32'h0, 1'b1, 32'h0);
        drive(4'b0000, 32'hbfafe004, 32'h0, 1'b1, 32'h0);
        for (int i = 0; i < 4; i++) begin
            exp = sb.pop_front();
            if (i == 3) begin
                checks++;
                if (rdata !== exp) begin errors++; $display("[TB] FAIL notimer_rd: got 0x%08h, expected 0x%08h", rdata, exp); end
            end
        end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (timerInt !== 1'b0) begin errors++; $display("[TB] FAIL notimer_int[%0d]: got %b, expected 0", i, timerInt); end
            idle(1);
        end
    endtask
`endif

    task automatic test_reset_midwrite;
        logic [31:0] exp;
        drive(4'b1111, 32'h20, 32'hCAFEF00D, 1'b0, 32'h0);
        drive(4'b0000, 32'h20, 32'h0, 1'b1, 32'hCAFEF00D);
        exp = sb.pop_front();
        checks++; if (rdata !== exp) begin errors++; $display("[TB] FAIL pre_reset: got 0x%08h, expected 0x%08h", rdata, exp); end
        en = 1'b1; wen = 4'b1111; addr = 32'hbfaff000; wdata = 32'h00005555;
        #2 resetn = 1'b0;
        #1;
        checks++; if (led !== 16'h0) begin errors++; $display("[TB] FAIL rst_led: got 0x%04h, expected 0x0000", led); end
        checks++; if (rdata !== 32'h0) begin errors++; $display("[TB] FAIL rst_rdata: got 0x%08h, expected 0x00000000", rdata); end
        checks++; if (timerInt !== 1'b0) begin errors++; $display("[TB] FAIL rst_int: got %b, expected 0", timerInt); end
        addr = 32'h20; wdata = 32'h12345678;
        @(posedge clk); #1;
        en = 1'b0; wen = 4'b0000;
        @(negedge clk) resetn = 1'b1;
        @(posedge clk); #1;
        checks++; if (led !== 16'h0) begin errors++; $display("[TB] FAIL rst_led_after: got 0x%04h, expected 0x0000", led); end
        drive(4'b0000, 32'h20, 32'h0, 1'b1, 32'hCAFEF00D);
        exp = sb.pop_front();
        checks++; if (rdata !== exp) begin errors++; $display("[TB] FAIL rst_no_write: got 0x%08h, expected 0x%08h", rdata, exp); end
    endtask

    initial begin
        test_reset();
        test_ram_lanes();
        test_read_first_hold();
        test_led_io();
        test_switch_sync();
        test_timer();
        test_reset_midwrite();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
